fetch_unit: RTL

//  Program-counter and fetch stage of the TinyChip core; sits directly upstream of instruction_memory.

---
 rtl/tinychip_pkg.sv | 15 +
 rtl/jump_lut.sv | 25 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/tinychip_pkg.sv
// Shared TinyChip types and widths for the fetch stage and its jump-target LUT.
package tinychip_pkg;
  localparam int PC_W      = 8;
  localparam int INSTR_W   = 9;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one posedge write port, one asynchronous read port.
// A read of the entry being written in the same cycle returns the old value.
module jump_lut
  import tinychip_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] widx,
  input  pc_t                  wdata,
  input  logic [LUT_IDX_W-1:0] ridx,
  output pc_t                  rdata
);
  pc_t mem [LUT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];
endmodule

// File: rtl/fetch_unit.sv
// TinyChip program counter and IF/ID register with jump/branch redirect, stall and halt.
// Optional feature macro FETCH_JUMP_LUT_EN: jumps index a programmable target LUT.
module fetch_unit
  import tinychip_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output pc_t                  addr,
  input  instr_t               instr_in,
  input  logic                 imem_done,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  pc_t                  branch_off,
  input  logic                 jump,
  input  pc_t                  jump_target,
`ifdef FETCH_JUMP_LUT_EN
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  pc_t                  lut_data,
`endif
  output instr_t               ir_out,
  output pc_t                  ir_pc,
  output logic                 ir_valid,
  output logic                 halted,
  output fetch_state_e         state_dbg
);
  // Handshake: ir_valid is the valid; stall is the inverse of downstream ready.
  // While stall is high with no redirect, the IR and pc hold, so a valid word is
  // never lost or duplicated; redirects and halt take effect regardless of stall.
  fetch_state_e state_q, state_d;
  pc_t          pc_q, pc_d, jump_pc;
  instr_t       ir_d;
  pc_t          ir_pc_d;
  logic         valid_d, halted_d, fetched_q, fetched_d;

`ifdef FETCH_JUMP_LUT_EN
  jump_lut u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .widx  (lut_idx),
    .wdata (lut_data),
    .ridx  (jump_target[LUT_IDX_W-1:0]),
    .rdata (jump_pc)
  );
`else
  assign jump_pc = jump_target;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      ir_out    <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      fetched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_out    <= ir_d;
      ir_pc     <= ir_pc_d;
      ir_valid  <= valid_d;
      halted    <= halted_d;
      fetched_q <= fetched_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_out;
    ir_pc_d   = ir_pc;
    valid_d   = ir_valid;
    halted_d  = halted;
    fetched_d = fetched_q;
    unique case (state_q)
      RUN: begin
        // imem_done refers to the previous cycle's address; without a real
        // fetch behind it (after reset or a redirect) the flag is meaningless.
        if (fetched_q && imem_done) begin
          state_d  = HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else if (jump) begin
          pc_d      = jump_pc;
          valid_d   = 1'b0;
          fetched_d = 1'b0;
        end else if (branch_taken) begin
          pc_d      = ir_pc + branch_off;
          valid_d   = 1'b0;
          fetched_d = 1'b0;
        end else if (!stall) begin
          ir_d      = instr_in;
          ir_pc_d   = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + pc_t'(1);
          fetched_d = 1'b1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign addr      = pc_q;
  assign state_dbg = state_q;
endmodule
